// File: rtl/cpu_types.sv
// ----------------------------------------------------------------------------
// cpu_types
//   Shared type definitions for the CPU memory subsystem.
//
//   arb_state_t : memory arbiter sequencing states (IDLE -> ACCESS -> RESP)
//   owner_t     : which requester owns the access in flight
//   arb_pick_data() : grant helper used by mem_arbiter
//
//   Optional feature macro consumed by mem_arbiter: MEM_ARB_RR_EN
// ----------------------------------------------------------------------------
package cpu_types;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   // Owner of the latched access.
   typedef enum logic {
      OWNER_IF   = 1'b0,
      OWNER_DATA = 1'b1
   } owner_t;

   // Number of byte lanes on the shared RAM port.
   localparam int BE_W = 4;

   // Byte-enable pattern used for instruction fetches (whole word read).
   localparam logic [BE_W-1:0] FETCH_BE = 4'b1111;

   // Returns 1 when the data port should be granted.
   // data_first only matters when both ports request in the same cycle.
   function automatic logic arb_pick_data(input logic if_req,
                                          input logic d_req,
                                          input logic data_first);
      arb_pick_data = d_req && (!if_req || data_first);
   endfunction

endpackage : cpu_types

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported RAM between an instruction-fetch port and a
//   data (load/store) port. Each access takes three cycles:
//     IDLE   : pick a winner, latch its request onto the mem_* registers
//     ACCESS : mem_* drive the RAM for exactly one cycle; read data is
//              captured into the owner's rdata register at the closing edge
//     RESP   : owner's ack pulses for one cycle, then back to IDLE
//
//   Optional feature (macro MEM_ARB_RR_EN):
//     defined   : contested grants alternate, data first after reset; the
//                 pointer only flips when both ports requested together.
//     undefined : fixed priority, data port over fetch port.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   if_req/if_addr    fetch request (held until if_ack) and word address
//   if_ack/if_rdata   one-cycle completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata/d_byte_enable
//                     data request (held until d_ack), write flag, address,
//                     store data and store byte lanes
//   d_ack/d_rdata     one-cycle completion pulse and load data
//   mem_address/mem_write/mem_byte_enable/mem_we
//                     shared RAM request, valid only in ACCESS
//   mem_out           shared RAM combinational read data
//   dbg_state         current FSM state, for observation only
//
// Handshake: a requester raises req with its fields and holds them until it
// sees ack. Fields are sampled once, in IDLE, on the edge that grants the
// port; later changes do not affect the access in flight. ack is high for
// exactly one cycle, never on both ports at once.
// ----------------------------------------------------------------------------
import cpu_types::*;

module mem_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,

   // fetch port
   input  logic             if_req,
   input  logic [WIDTH-1:0] if_addr,
   output logic             if_ack,
   output logic [WIDTH-1:0] if_rdata,

   // data port
   input  logic             d_req,
   input  logic             d_we,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   input  logic [BE_W-1:0]  d_byte_enable,
   output logic             d_ack,
   output logic [WIDTH-1:0] d_rdata,

   // shared RAM
   output logic [WIDTH-1:0] mem_address,
   output logic [WIDTH-1:0] mem_write,
   output logic [BE_W-1:0]  mem_byte_enable,
   output logic             mem_we,
   input  logic [WIDTH-1:0] mem_out,

   // observation
   output arb_state_t       dbg_state
);

   arb_state_t state;
   owner_t     owner;
   logic       grant_data;
   logic       contested;

   assign contested = if_req && d_req;
   assign dbg_state = state;

   // -------------------------------------------------------------------------
   // Grant selection
   // -------------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
   // 1: data port wins the next contested grant, 0: fetch port wins it.
   logic rr_data_first;

   always_comb begin
      grant_data = arb_pick_data(if_req, d_req, rr_data_first);
   end

   // Flip only on a contested grant so an uncontested access never steals
   // the other port's turn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_data_first <= 1'b1;
      end else if (state == IDLE && contested) begin
         rr_data_first <= !grant_data;
      end
   end
`else
   always_comb begin
      grant_data = arb_pick_data(if_req, d_req, 1'b1);
   end
`endif

   // -------------------------------------------------------------------------
   // Sequencing FSM. The mem_* outputs double as the latched request, so
   // they are loaded on the granting edge and are valid for the whole
   // ACCESS cycle. Byte enables and write enable are cleared on leaving
   // ACCESS; address and write data simply hold.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         owner           <= OWNER_DATA;
         mem_address     <= '0;
         mem_write       <= '0;
         mem_byte_enable <= '0;
         mem_we          <= 1'b0;
         if_ack          <= 1'b0;
         d_ack           <= 1'b0;
         if_rdata        <= '0;
         d_rdata         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if_ack <= 1'b0;
               d_ack  <= 1'b0;
               if (if_req || d_req) begin
                  state <= ACCESS;
                  if (grant_data) begin
                     owner           <= OWNER_DATA;
                     mem_address     <= d_addr;
                     mem_write       <= d_wdata;
                     mem_byte_enable <= d_byte_enable;
                     mem_we          <= d_we;
                  end else begin
                     // Fetches are always whole-word reads.
                     owner           <= OWNER_IF;
                     mem_address     <= if_addr;
                     mem_write       <= '0;
                     mem_byte_enable <= FETCH_BE;
                     mem_we          <= 1'b0;
                  end
               end
            end

            ACCESS: begin
               state           <= RESP;
               mem_we          <= 1'b0;
               mem_byte_enable <= '0;
               if (owner == OWNER_IF) begin
                  if_rdata <= mem_out;
                  if_ack   <= 1'b1;
               end else begin
                  // Stores leave d_rdata untouched.
                  if (!mem_we) begin
                     d_rdata <= mem_out;
                  end
                  d_ack <= 1'b1;
               end
            end

            RESP: begin
               state  <= IDLE;
               if_ack <= 1'b0;
               d_ack  <= 1'b0;
            end

            default: begin
               state           <= IDLE;
               mem_we          <= 1'b0;
               mem_byte_enable <= '0;
               if_ack          <= 1'b0;
               d_ack           <= 1'b0;
            end
         endcase
      end
   end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural byte-lane RAM.
//   Table of single transactions, then hand-written sequences for the
//   contested grant, round-robin order, late request changes and a reset
//   landing in the middle of a write.
// ----------------------------------------------------------------------------
import cpu_types::*;

module tb_mem_arbiter;

   localparam int W = 32;

   // -------------------------------------------------------------------------
   // Clock / reset
   // -------------------------------------------------------------------------
   logic clk;
   logic rst_n;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // -------------------------------------------------------------------------
   // DUT
   // -------------------------------------------------------------------------
   logic          if_req, if_ack;
   logic [W-1:0]  if_addr, if_rdata;
   logic          d_req, d_we, d_ack;
   logic [W-1:0]  d_addr, d_wdata, d_rdata;
   logic [3:0]    d_byte_enable;
   logic [W-1:0]  mem_address, mem_write, mem_out;
   logic [3:0]    mem_byte_enable;
   logic          mem_we;
   arb_state_t    dbg_state;

   mem_arbiter #(.WIDTH(W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .if_req          (if_req),
      .if_addr         (if_addr),
      .if_ack          (if_ack),
      .if_rdata        (if_rdata),
      .d_req           (d_req),
      .d_we            (d_we),
      .d_addr          (d_addr),
      .d_wdata         (d_wdata),
      .d_byte_enable   (d_byte_enable),
      .d_ack           (d_ack),
      .d_rdata         (d_rdata),
      .mem_address     (mem_address),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_we          (mem_we),
      .mem_out         (mem_out),
      .dbg_state       (dbg_state)
   );

   // -------------------------------------------------------------------------
   // RAM model: 64 words, byte lanes, plus a backdoor load port
   // -------------------------------------------------------------------------
   logic [W-1:0] ram [0:63];
   logic         bd_we;
   logic [5:0]   bd_idx;
   logic [W-1:0] bd_data;

   always @(posedge clk) begin
      if (bd_we) begin
         ram[bd_idx] <= bd_data;
      end else if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) ram[mem_address[7:2]][8*b +: 8] <= mem_write[8*b +: 8];
         end
      end
   end

   assign mem_out = ram[mem_address[7:2]];

   // -------------------------------------------------------------------------
   // Scoreboard
   // -------------------------------------------------------------------------
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_d;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // -------------------------------------------------------------------------
   // Driver tasks
   // -------------------------------------------------------------------------
   task automatic idle_inputs();
      if_req        = 1'b0;
      if_addr       = '0;
      d_req         = 1'b0;
      d_we          = 1'b0;
      d_addr        = '0;
      d_wdata       = '0;
      d_byte_enable = '0;
   endtask

   task automatic backdoor(input logic [W-1:0] addr, input logic [W-1:0] data);
      @(negedge clk);
      bd_we   = 1'b1;
      bd_idx  = addr[7:2];
      bd_data = data;
      @(negedge clk);
      bd_we   = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      last_d = '0;
      @(negedge clk);
   endtask

   typedef struct {
      string        name;
      logic         fetch;
      logic         we;
      logic [W-1:0] addr;
      logic [W-1:0] wdata;
      logic [3:0]   be;
      logic [W-1:0] exp_rdata;   // ignored for writes (d_rdata must hold)
   } vec_t;

   // One isolated transaction. Inputs change on negedges; cycle n is the
   // negedge after the n-th rising edge, counting the sampling edge as 1.
   task automatic run_txn(input vec_t v);
      int   ack_cyc;
      logic saw_we;
      logic other_ack;
      logic [W-1:0] addr_in_access;
      ack_cyc        = 0;
      saw_we         = 1'b0;
      other_ack      = 1'b0;
      addr_in_access = '1;
      @(negedge clk);
      if (v.fetch) begin
         if_req  = 1'b1;
         if_addr = v.addr;
      end else begin
         d_req         = 1'b1;
         d_we          = v.we;
         d_addr        = v.addr;
         d_wdata       = v.wdata;
         d_byte_enable = v.be;
      end
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (mem_we) saw_we = 1'b1;
         if (c == 1) addr_in_access = mem_address;
         if (v.fetch ? d_ack : if_ack) other_ack = 1'b1;
         if (v.fetch ? if_ack : d_ack) begin
            ack_cyc = c;
            idle_inputs();
            break;
         end
      end
      check({v.name, "_ack_latency"}, ack_cyc, 2);
      check({v.name, "_mem_address"}, addr_in_access, v.addr);
      check({v.name, "_mem_we_seen"}, {31'd0, saw_we}, {31'd0, v.we && !v.fetch});
      check({v.name, "_other_ack"}, {31'd0, other_ack}, 32'd0);
      check({v.name, "_be_idle_in_resp"}, {28'd0, mem_byte_enable}, 32'd0);
      if (v.fetch) begin
         check({v.name, "_if_rdata"}, if_rdata, v.exp_rdata);
      end else if (v.we) begin
         check({v.name, "_d_rdata_held"}, d_rdata, last_d);
      end else begin
         check({v.name, "_d_rdata"}, d_rdata, v.exp_rdata);
         last_d = v.exp_rdata;
      end
      @(negedge clk);   // RESP -> IDLE
   endtask

   // -------------------------------------------------------------------------
   // Test
   // -------------------------------------------------------------------------
   vec_t vecs [10];

   initial begin
      int d_at, if_at, acks, waited;
      logic both_acks;

      vecs[0] = '{"wr4",      1'b0, 1'b1, 32'h4, 32'd10,        4'hF, 32'h0};
      vecs[1] = '{"rd4",      1'b0, 1'b0, 32'h4, 32'h0,         4'hF, 32'h0000000A};
      vecs[2] = '{"fetch8",   1'b1, 1'b0, 32'h8, 32'h0,         4'h0, 32'h00A00113};
      vecs[3] = '{"wrC",      1'b0, 1'b1, 32'hC, 32'h11223344,  4'hF, 32'h0};
      vecs[4] = '{"wrC_lane", 1'b0, 1'b1, 32'hC, 32'hAABBCCDD,  4'h5, 32'h0};
      vecs[5] = '{"rdC",      1'b0, 1'b0, 32'hC, 32'h0,         4'hF, 32'h11BB33DD};
      vecs[6] = '{"fetchC",   1'b1, 1'b0, 32'hC, 32'h0,         4'h0, 32'h11BB33DD};
      vecs[7] = '{"wr4_nobe", 1'b0, 1'b1, 32'h4, 32'hFFFFFFFF,  4'h0, 32'h0};
      vecs[8] = '{"rd4_again",1'b0, 1'b0, 32'h4, 32'h0,         4'hF, 32'h0000000A};
      vecs[9] = '{"fetch4",   1'b1, 1'b0, 32'h4, 32'h0,         4'h0, 32'h0000000A};

      rst_n   = 1'b0;
      bd_we   = 1'b0;
      bd_idx  = '0;
      bd_data = '0;
      last_d  = '0;
      idle_inputs();

      // Preload while held in reset.
      backdoor(32'h0,  32'h00000055);
      backdoor(32'h8,  32'h00A00113);
      backdoor(32'h10, 32'h00001234);

      // ---- reset state ----
      @(negedge clk);
      check("rst_state",    {30'd0, dbg_state}, {30'd0, IDLE});
      check("rst_if_ack",   {31'd0, if_ack}, 32'd0);
      check("rst_d_ack",    {31'd0, d_ack}, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_d_rdata",  d_rdata, 32'd0);
      check("rst_mem_we",   {31'd0, mem_we}, 32'd0);
      check("rst_mem_be",   {28'd0, mem_byte_enable}, 32'd0);
      check("rst_mem_addr", mem_address, 32'd0);
      check("rst_mem_wr",   mem_write, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- table of single transactions ----
      for (int i = 0; i < 10; i++) run_txn(vecs[i]);

      // ---- simultaneous requests: data first, fetch three cycles later ----
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h8;
      d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h4; d_byte_enable = 4'hF;
      d_at = 0; if_at = 0; both_acks = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (d_ack && if_ack) both_acks = 1'b1;
         if (d_ack)  begin d_at  = c; d_req  = 1'b0; end
         if (if_ack) begin if_at = c; if_req = 1'b0; end
         if (d_at != 0 && if_at != 0) break;
      end
      idle_inputs();
      check("contest_d_ack_cycle",  d_at, 2);
      check("contest_if_ack_cycle", if_at, 5);
      check("contest_both_acks",    {31'd0, both_acks}, 32'd0);
      check("contest_d_rdata",      d_rdata, 32'h0000000A);
      check("contest_if_rdata",     if_rdata, 32'h00A00113);
      @(negedge clk);

      // ---- both held for four accesses: grant order from a fresh reset ----
      apply_reset();
`ifdef MEM_ARB_RR_EN
      exp_q = '{32'd1, 32'd0, 32'd1, 32'd0};
`else
      exp_q = '{32'd1, 32'd1, 32'd1, 32'd1};
`endif
      if_req = 1'b1; if_addr = 32'h8;
      d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h4; d_byte_enable = 4'hF;
      acks = 0; waited = 0;
      while (acks < 4 && waited < 20) begin
         @(posedge clk);
         @(negedge clk);
         waited++;
         if (d_ack && if_ack) check("rr_both_acks", 32'd1, 32'd0);
         if (d_ack || if_ack) begin
            acks++;
            check($sformatf("rr_grant_%0d", acks), {31'd0, d_ack}, exp_q.pop_front());
         end
      end
      check("rr_ack_count", acks, 4);
      idle_inputs();
      repeat (2) @(negedge clk);

      // ---- address change after latching does not affect the access ----
      backdoor(32'h4, 32'h0000000A);
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4; d_byte_enable = 4'hF;
      @(posedge clk);
      @(negedge clk);
      d_addr = 32'h10;
      check("late_addr_mem_address", mem_address, 32'h4);
      d_at = 0;
      for (int c = 2; c <= 8; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (d_ack) begin d_at = c; break; end
      end
      idle_inputs();
      check("late_addr_ack_cycle", d_at, 2);
      check("late_addr_d_rdata",   d_rdata, 32'h0000000A);
      @(negedge clk);

      // ---- reset in the middle of a write ----
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'h0000DEAD; d_byte_enable = 4'hF;
      @(posedge clk);
      @(negedge clk);
      check("abort_in_access", {30'd0, dbg_state}, {30'd0, ACCESS});
      rst_n = 1'b0;
      idle_inputs();
      #1;
      check("abort_state_idle", {30'd0, dbg_state}, {30'd0, IDLE});
      check("abort_mem_we",     {31'd0, mem_we}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      both_acks = 1'b0;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
         if (d_ack || if_ack) both_acks = 1'b1;
      end
      check("abort_no_ack",   {31'd0, both_acks}, 32'd0);
      check("abort_ram0",     ram[0], 32'h00000055);
      check("abort_end_idle", {30'd0, dbg_state}, {30'd0, IDLE});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mem_arbiter
